xy_noc_switch: RTL and testbench
================================

Name: xy_noc_switch

Overview:
- Five-port (parameterizable) mesh-NoC router node at coordinate (X_CORD, Y_CORD).
- Each input port has a FIFO. Packets are routed with dimension-ordered XY routing.
- Each output port has a single-packet output register feeding the neighbour's input FIFO.
- It is instantiated once per mesh tile between the local resource and up to four neighbours.

Parameters:
- X_CORD, 0, switch X coordinate in mesh.
- Y_CORD, 0, switch Y coordinate in mesh.
- PORT_N, 5, number of ports (1..5). Index map: 0=resource(local), 1=north, 2=east, 3=south, 4=west.
- IN_FIFO_DEPTH_W, 3, log2 of input FIFO depth (depth = 2**IN_FIFO_DEPTH_W = 8).
- PCKT_XADDR_W, 4, destination X field width.
- PCKT_YADDR_W, 4, destination Y field width.
- PCKT_DATA_W, 8, payload width.
- PCKT_W, XADDR_W+YADDR_W+DATA_W (16), packet width.
- SW_CONFIG, 0, output arbitration: 0 = round-robin, nonzero = fixed priority (lowest input index wins).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_ni  in  1  synchronous, active-high reset (name retained from codebase).
- wr_en_sw_i  in  PORT_N  per-port write strobe into input FIFO.
- pckt_sw_i  in  PCKT_W*PORT_N  per-port packets; port p occupies bits [p*PCKT_W +: PCKT_W].
- in_fifo_full_o  out  PORT_N  input FIFO p holds depth entries.
- in_fifo_overflow_o  out  PORT_N  write attempted into full FIFO p.
- nxt_fifo_full_i  in  PORT_N  downstream FIFO on output p is full.
- nxt_fifo_overflow_i  in  PORT_N  downstream FIFO on output p overflowed.
- wr_en_sw_o  out  PORT_N  output p carries a valid packet this cycle.
- pckt_sw_o  out  PCKT_W*PORT_N  output packets; same lane packing as the input.

Behaviour:
- Packet format, MSB to LSB:
  - dest X = [PCKT_W-1 -: XADDR_W]
  - dest Y = next YADDR_W bits
  - data = [DATA_W-1:0]
- Packets are forwarded unmodified.
- Reset (rst_ni=1 at a clock edge):
  - all FIFOs emptied;
  - wr_en_sw_o = 0, pckt_sw_o = 0;
  - in_fifo_overflow_o = 0;
  - round-robin pointers set to input 0.
  - Reset mid-traffic discards all buffered packets.
- Input FIFO:
  - wr_en_sw_i[p] with FIFO not full pushes the packet on that edge.
  - in_fifo_full_o[p] is combinational from the occupancy count (count == depth).
  - A write while full drops the packet and sets in_fifo_overflow_o[p] high for exactly the next cycle (registered pulse, non-sticky).
  - A push and a pop in the same cycle are allowed even when the FIFO is full: the pop frees a slot first, so no overflow.
- Routing of each non-empty FIFO head, with unsigned compares:
  - dx > X_CORD -> east(2);
  - dx < X_CORD -> west(4);
  - else dy > Y_CORD -> north(1);
  - dy < Y_CORD -> south(3);
  - else resource(0).
  - If the target index >= PORT_N, the head is popped and discarded with no output.
- Arbitration, per output o, each cycle:
  - Requesters are the heads routed to o.
  - o is eligible when nxt_fifo_full_i[o]=0 and nxt_fifo_overflow_i[o]=0.
  - One winner per output. Each input can win at most one output (each head has exactly one target).
  - Round-robin: the search starts at the index after the last winner, and the pointer updates only on a grant.
- Output register:
  - On a grant, the winner's FIFO is popped. The packet is registered into pckt_sw_o lane o, with wr_en_sw_o[o]=1 for one cycle.
  - Without a grant, wr_en_sw_o[o]=0 and pckt_sw_o lane o holds its previous value.
- Latency: a packet written at edge N to an empty FIFO, with no contention and an eligible output, appears with wr_en_sw_o high after edge N+2.
- Throughput: 1 packet/cycle per output and per input.
- Backpressure:
  - While nxt_fifo_full_i[o]=1, no new grant goes to o. Packets stay buffered; nothing is lost.
  - The downstream must absorb the one packet already registered.
- A packet whose destination equals (X_CORD, Y_CORD) arriving on input 0 is looped back to output 0.

Test Plan:
- Reset check: assert rst_ni for 2 cycles with stimulus active -> all outputs 0, FIFOs empty; first packet after release still takes 2 cycles.
- Routing, at X_CORD=0, Y_CORD=0 with 2x2-reachable destinations, each packet injected on port 0:
  - 0x1055 (dx=1, dy=0) -> wr_en_sw_o[2], lane 2 = 0x1055 at N+2;
  - 0x0177 -> port 1;
  - 0x00AA -> port 0.
- Backpressure: nxt_fifo_full_i[2]=1, push 3 east packets -> no wr_en_sw_o[2]. Release -> 3 packets out on consecutive cycles, in order.
- Overflow: hold nxt_fifo_full_i[2]=1, write 9 east packets to port 0 -> in_fifo_full_o[0]=1 after the 8th write; the 9th write pulses in_fifo_overflow_o[0] one cycle; only 8 packets later emerge.
- Contention: ports 1, 3 and 4 each push a resource-bound packet in the same cycle, SW_CONFIG=0 -> output 0 emits three packets on consecutive cycles in order 1, 3, 4. With SW_CONFIG=1 and continuous traffic, port 1 always wins.
- Dropped route: PORT_N=3, packet needing west -> discarded, no wr_en_sw_o, FIFO drains.

Source files
------------

// File: rtl/xy_noc_switch.sv
// Mesh NoC router node: per-input FIFOs, dimension-ordered XY routing and
// one registered packet slot per output, arbitrated round-robin or fixed priority.
module xy_noc_switch #(
  parameter int X_CORD          = 0,
  parameter int Y_CORD          = 0,
  parameter int PORT_N          = 5,
  parameter int IN_FIFO_DEPTH_W = 3,
  parameter int PCKT_XADDR_W    = 4,
  parameter int PCKT_YADDR_W    = 4,
  parameter int PCKT_DATA_W     = 8,
  parameter int PCKT_W          = PCKT_XADDR_W + PCKT_YADDR_W + PCKT_DATA_W,
  parameter int SW_CONFIG       = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [PORT_N-1:0]        wr_en_sw_i,
  input  logic [PCKT_W*PORT_N-1:0] pckt_sw_i,
  output logic [PORT_N-1:0]        in_fifo_full_o,
  output logic [PORT_N-1:0]        in_fifo_overflow_o,
  input  logic [PORT_N-1:0]        nxt_fifo_full_i,
  input  logic [PORT_N-1:0]        nxt_fifo_overflow_i,
  output logic [PORT_N-1:0]        wr_en_sw_o,
  output logic [PCKT_W*PORT_N-1:0] pckt_sw_o
);

  localparam int LP_DEPTH = 1 << IN_FIFO_DEPTH_W;
  localparam int LP_IDX_W = (PORT_N > 1) ? $clog2(PORT_N) : 1;
  localparam logic [PCKT_XADDR_W-1:0] LP_X = PCKT_XADDR_W'(X_CORD);
  localparam logic [PCKT_YADDR_W-1:0] LP_Y = PCKT_YADDR_W'(Y_CORD);

  logic [PCKT_W-1:0]          r_mem  [PORT_N][LP_DEPTH];
  logic [IN_FIFO_DEPTH_W-1:0] r_wptr [PORT_N];
  logic [IN_FIFO_DEPTH_W-1:0] r_rptr [PORT_N];
  logic [IN_FIFO_DEPTH_W:0]   r_cnt  [PORT_N];
  logic [PORT_N-1:0]          r_hd_vld;
  logic [PORT_N-1:0]          r_ovf;
  logic [LP_IDX_W-1:0]        r_rr   [PORT_N];
  logic [PORT_N-1:0]          r_wr_o;
  logic [PCKT_W-1:0]          r_pk_o [PORT_N];

  logic [PCKT_W-1:0]          w_head     [PORT_N];
  logic [2:0]                 w_tgt      [PORT_N];
  logic [LP_IDX_W-1:0]        w_gnt_idx  [PORT_N];
  logic [IN_FIFO_DEPTH_W:0]   w_cnt_nxt  [PORT_N];
  logic [IN_FIFO_DEPTH_W-1:0] w_rptr_nxt [PORT_N];
  logic [PORT_N-1:0]          w_full;
  logic [PORT_N-1:0]          w_drop;
  logic [PORT_N-1:0]          w_gnt_vld;
  logic [PORT_N-1:0]          w_pop;
  logic [PORT_N-1:0]          w_push;
  logic [PORT_N-1:0]          w_hd_nxt;

  function automatic logic [2:0] f_route(input logic [PCKT_W-1:0] pk);
    logic [PCKT_XADDR_W-1:0] dx;
    logic [PCKT_YADDR_W-1:0] dy;
    dx = pk[PCKT_W-1 -: PCKT_XADDR_W];
    dy = pk[PCKT_W-1-PCKT_XADDR_W -: PCKT_YADDR_W];
    if (dx > LP_X)      f_route = 3'd2;
    else if (dx < LP_X) f_route = 3'd4;
    else if (dy > LP_Y) f_route = 3'd1;
    else if (dy < LP_Y) f_route = 3'd3;
    else                f_route = 3'd0;
  endfunction

  // Head packet, its route, and whether the route leaves the switch (discard).
  always_comb begin
    for (int p = 0; p < PORT_N; p++) begin
      w_head[p] = r_mem[p][r_rptr[p]];
      w_tgt[p]  = f_route(w_head[p]);
      w_full[p] = (r_cnt[p] == (IN_FIFO_DEPTH_W+1)'(LP_DEPTH));
      w_drop[p] = r_hd_vld[p] && (int'(w_tgt[p]) >= PORT_N);
    end
  end

  // Per-output arbitration, then pop/push and next-state FIFO bookkeeping.
  always_comb begin
    int                  pos;
    logic [LP_IDX_W-1:0] sel;
    logic                hit;
    pos       = 0;
    sel       = '0;
    hit       = 1'b0;
    w_gnt_vld = '0;
    w_pop     = '0;
    w_push    = '0;
    w_hd_nxt  = '0;
    for (int o = 0; o < PORT_N; o++) begin
      w_gnt_idx[o] = '0;
      for (int k = 0; k < PORT_N; k++) begin
        pos = (SW_CONFIG != 0) ? k : int'(r_rr[o]) + k + 1;
        pos = (pos >= PORT_N) ? pos - PORT_N : pos;
        sel = LP_IDX_W'(pos);
        hit = !w_gnt_vld[o] && !nxt_fifo_full_i[o] && !nxt_fifo_overflow_i[o] &&
              r_hd_vld[sel] && (w_tgt[sel] == 3'(o));
        w_gnt_vld[o] = w_gnt_vld[o] | hit;
        w_gnt_idx[o] = hit ? sel : w_gnt_idx[o];
        w_pop[sel]   = w_pop[sel] | hit;
      end
    end
    for (int p = 0; p < PORT_N; p++) begin
      w_pop[p]      = w_pop[p] | w_drop[p];
      w_push[p]     = wr_en_sw_i[p] && (!w_full[p] || w_pop[p]);
      w_cnt_nxt[p]  = r_cnt[p] + (IN_FIFO_DEPTH_W+1)'(w_push[p]) - (IN_FIFO_DEPTH_W+1)'(w_pop[p]);
      w_rptr_nxt[p] = r_rptr[p] + IN_FIFO_DEPTH_W'(w_pop[p]);
      // A packet that lands at the head on this edge becomes routable one cycle later.
      w_hd_nxt[p]   = (w_cnt_nxt[p] != '0) && !(w_push[p] && (r_wptr[p] == w_rptr_nxt[p]));
    end
  end

  // Input FIFO storage, pointers, occupancy and overflow pulse.
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      for (int p = 0; p < PORT_N; p++) begin
        r_wptr[p] <= '0;
        r_rptr[p] <= '0;
        r_cnt[p]  <= '0;
      end
      r_hd_vld <= '0;
      r_ovf    <= '0;
    end else begin
      for (int p = 0; p < PORT_N; p++) begin
        if (w_push[p]) begin
          r_mem[p][r_wptr[p]] <= pckt_sw_i[p*PCKT_W +: PCKT_W];
          r_wptr[p]           <= r_wptr[p] + 1'b1;
        end
        r_rptr[p] <= w_rptr_nxt[p];
        r_cnt[p]  <= w_cnt_nxt[p];
      end
      r_hd_vld <= w_hd_nxt;
      r_ovf    <= wr_en_sw_i & w_full & ~w_pop;
    end
  end

  // Output registers and round-robin pointers (pointer = last winner).
  always_ff @(posedge clk_i) begin
    if (rst_ni) begin
      r_wr_o <= '0;
      for (int o = 0; o < PORT_N; o++) begin
        r_pk_o[o] <= '0;
        r_rr[o]   <= '0;
      end
    end else begin
      r_wr_o <= w_gnt_vld;
      for (int o = 0; o < PORT_N; o++) begin
        if (w_gnt_vld[o]) begin
          r_pk_o[o] <= w_head[w_gnt_idx[o]];
          r_rr[o]   <= w_gnt_idx[o];
        end
      end
    end
  end

  // Pack output lanes.
  always_comb begin
    pckt_sw_o = '0;
    for (int o = 0; o < PORT_N; o++) begin
      pckt_sw_o[o*PCKT_W +: PCKT_W] = r_pk_o[o];
    end
  end

  assign in_fifo_full_o     = w_full;
  assign in_fifo_overflow_o = r_ovf;
  assign wr_en_sw_o         = r_wr_o;

endmodule

// File: tb/tb_xy_noc_switch.sv
// Bench for xy_noc_switch: three instances (origin RR, 3-port fixed priority, interior RR)
// checked by directed scenarios and a queue-based reference model.
module tb_xy_noc_switch;
  localparam int ND    = 3;
  localparam int DEPTH = 8;
  localparam int PX  [ND] = '{0, 2, 1};
  localparam int PY  [ND] = '{0, 1, 2};
  localparam int PN  [ND] = '{5, 3, 5};
  localparam int CFG [ND] = '{0, 1, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [4:0]  in_wr [ND];
  logic [79:0] in_pk [ND];
  logic [4:0]  in_nfull [ND];
  logic [4:0]  in_novf [ND];

  logic [4:0]  a_full, a_ovf, a_wr, c_full, c_ovf, c_wr;
  logic [2:0]  b_full, b_ovf, b_wr;
  logic [79:0] a_pk, c_pk;
  logic [47:0] b_pk;
  logic [4:0]  ob_full [ND];
  logic [4:0]  ob_ovf [ND];
  logic [4:0]  ob_wr [ND];
  logic [79:0] ob_pk [ND];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  xy_noc_switch #(.X_CORD(0), .Y_CORD(0), .PORT_N(5), .SW_CONFIG(0)) u_dut_a (
    .clk_i(clk), .rst_ni(rst), .wr_en_sw_i(in_wr[0]), .pckt_sw_i(in_pk[0]),
    .in_fifo_full_o(a_full), .in_fifo_overflow_o(a_ovf),
    .nxt_fifo_full_i(in_nfull[0]), .nxt_fifo_overflow_i(in_novf[0]),
    .wr_en_sw_o(a_wr), .pckt_sw_o(a_pk));

  xy_noc_switch #(.X_CORD(2), .Y_CORD(1), .PORT_N(3), .SW_CONFIG(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst), .wr_en_sw_i(in_wr[1][2:0]), .pckt_sw_i(in_pk[1][47:0]),
    .in_fifo_full_o(b_full), .in_fifo_overflow_o(b_ovf),
    .nxt_fifo_full_i(in_nfull[1][2:0]), .nxt_fifo_overflow_i(in_novf[1][2:0]),
    .wr_en_sw_o(b_wr), .pckt_sw_o(b_pk));

  xy_noc_switch #(.X_CORD(1), .Y_CORD(2), .PORT_N(5), .SW_CONFIG(0)) u_dut_c (
    .clk_i(clk), .rst_ni(rst), .wr_en_sw_i(in_wr[2]), .pckt_sw_i(in_pk[2]),
    .in_fifo_full_o(c_full), .in_fifo_overflow_o(c_ovf),
    .nxt_fifo_full_i(in_nfull[2]), .nxt_fifo_overflow_i(in_novf[2]),
    .wr_en_sw_o(c_wr), .pckt_sw_o(c_pk));

  always_comb begin
    ob_full[0] = a_full;          ob_ovf[0] = a_ovf;          ob_wr[0] = a_wr;          ob_pk[0] = a_pk;
    ob_full[1] = {2'b00, b_full}; ob_ovf[1] = {2'b00, b_ovf}; ob_wr[1] = {2'b00, b_wr}; ob_pk[1] = {32'd0, b_pk};
    ob_full[2] = c_full;          ob_ovf[2] = c_ovf;          ob_wr[2] = c_wr;          ob_pk[2] = c_pk;
  end

  // ---------------- reference model: queues of (packet, push cycle) ----------------
  typedef struct {
    logic [15:0] pk;
    int          t;
  } ent_t;

  ent_t        q [ND][5][$];
  logic [4:0]  e_wr [ND];
  logic [4:0]  e_ovf [ND];
  logic [15:0] e_pk [ND][5];
  int          rr [ND][5];

  function automatic int route(input int d, input logic [15:0] pk);
    int dx, dy;
    dx = int'(pk[15:12]);
    dy = int'(pk[11:8]);
    if (dx > PX[d]) return 2;
    else if (dx < PX[d]) return 4;
    else if (dy > PY[d]) return 1;
    else if (dy < PY[d]) return 3;
    else return 0;
  endfunction

  task automatic model_step(input int d);
    int          hv [5];
    int          tg [5];
    int          pop [5];
    logic [15:0] hd [5];
    int          win, idx, pn;
    pn = PN[d];
    for (int p = 0; p < 5; p++) begin
      hv[p] = 0; tg[p] = -1; pop[p] = 0; hd[p] = 16'h0;
      // a packet becomes eligible two edges after the one that stored it
      if (p < pn && q[d][p].size() > 0 && q[d][p][0].t + 1 < cyc) begin
        hv[p] = 1;
        hd[p] = q[d][p][0].pk;
        tg[p] = route(d, hd[p]);
        if (tg[p] >= pn) pop[p] = 1;
      end
    end
    e_wr[d] = 5'd0;
    for (int o = 0; o < pn; o++) begin
      if (!in_nfull[d][o] && !in_novf[d][o]) begin
        win = -1;
        for (int k = 0; k < pn; k++) begin
          idx = (CFG[d] != 0) ? k : (rr[d][o] + 1 + k) % pn;
          if (win < 0 && hv[idx] != 0 && tg[idx] == o) win = idx;
        end
        if (win >= 0) begin
          e_wr[d][o] = 1'b1;
          e_pk[d][o] = hd[win];
          pop[win]   = 1;
          rr[d][o]   = win;
        end
      end
    end
    e_ovf[d] = 5'd0;
    for (int p = 0; p < pn; p++) begin
      if (pop[p] != 0) void'(q[d][p].pop_front());
      if (in_wr[d][p]) begin
        if (q[d][p].size() < DEPTH) q[d][p].push_back('{pk: in_pk[d][p*16 +: 16], t: cyc});
        else e_ovf[d][p] = 1'b1;
      end
    end
  endtask

  always @(posedge clk) begin
    cyc = cyc + 1;
    for (int d = 0; d < ND; d++) begin
      if (rst) begin
        for (int p = 0; p < 5; p++) begin
          q[d][p].delete();
          e_pk[d][p] = 16'h0;
          rr[d][p]   = 0;
        end
        e_wr[d]  = 5'd0;
        e_ovf[d] = 5'd0;
      end else begin
        model_step(d);
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      for (int p = 0; p < PN[d]; p++) begin
        n_vec++;
        if (ob_wr[d][p] !== e_wr[d][p] || ob_ovf[d][p] !== e_ovf[d][p] ||
            ob_full[d][p] !== (q[d][p].size() == DEPTH) || ob_pk[d][p*16 +: 16] !== e_pk[d][p]) begin
          n_err++;
          $display("FAIL model dut%0d port%0d t=%0t: got wr=%b ovf=%b full=%b pk=%h, want wr=%b ovf=%b full=%b pk=%h",
                   d, p, $time, ob_wr[d][p], ob_ovf[d][p], ob_full[d][p], ob_pk[d][p*16 +: 16],
                   e_wr[d][p], e_ovf[d][p], (q[d][p].size() == DEPTH), e_pk[d][p]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc_n(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < ND; d++) begin
      in_wr[d] = 5'd0; in_pk[d] = 80'd0; in_nfull[d] = 5'd0; in_novf[d] = 5'd0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc_n(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    in_nfull[0] = 5'b00100;
    for (int i = 0; i < 4; i++) begin
      in_wr[0] = 5'b00001;
      in_pk[0][15:0] = 16'h1040 + 16'(i);
      cyc_n(1);
    end
    in_pk[0][15:0] = 16'h1077;
    rst = 1'b1;
    cyc_n(2);
    n_vec++;
    if (ob_wr[0] !== 5'd0 || ob_pk[0] !== 80'd0 || ob_full[0] !== 5'd0 || ob_ovf[0] !== 5'd0) begin
      n_err++;
      $display("FAIL reset_state: wr=%b pk=%h full=%b ovf=%b, want all zero", ob_wr[0], ob_pk[0], ob_full[0], ob_ovf[0]);
    end
    in_nfull[0] = 5'd0;
    rst = 1'b0;
    cyc_n(1);
    in_wr[0] = 5'd0;
    cyc_n(1);
    n_vec++;
    if (ob_wr[0] !== 5'd0) begin
      n_err++; $display("FAIL reset_latency_early: wr=%b, want 00000", ob_wr[0]);
    end
    cyc_n(1);
    n_vec++;
    if (ob_wr[0] !== 5'b00100 || ob_pk[0][32 +: 16] !== 16'h1077) begin
      n_err++; $display("FAIL reset_first_pkt: wr=%b lane2=%h, want 00100 1077", ob_wr[0], ob_pk[0][32 +: 16]);
    end
    cyc_n(1);
    n_vec++;
    if (ob_wr[0] !== 5'd0) begin
      n_err++; $display("FAIL reset_discard: wr=%b, want 00000", ob_wr[0]);
    end
  endtask

  task automatic test_routing();
    logic [15:0] pkv [3];
    int          exp_port [3];
    pkv = '{16'h1055, 16'h0177, 16'h00AA};
    exp_port = '{2, 1, 0};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_wr[0] = 5'b00001;
      in_pk[0][15:0] = pkv[i];
      cyc_n(1);
      in_wr[0] = 5'd0;
      cyc_n(2);
      n_vec++;
      if (ob_wr[0] !== (5'd1 << exp_port[i]) || ob_pk[0][exp_port[i]*16 +: 16] !== pkv[i]) begin
        n_err++;
        $display("FAIL route_%h: wr=%b lane=%h, want wr=%b lane=%h", pkv[i], ob_wr[0],
                 ob_pk[0][exp_port[i]*16 +: 16], (5'd1 << exp_port[i]), pkv[i]);
      end
      cyc_n(1);
      n_vec++;
      if (ob_wr[0] !== 5'd0) begin
        n_err++; $display("FAIL route_pulse_%h: wr=%b, want 00000", pkv[i], ob_wr[0]);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    in_nfull[0] = 5'b00100;
    for (int i = 0; i < 3; i++) begin
      in_wr[0] = 5'b00001;
      in_pk[0][15:0] = 16'h1001 + 16'(i);
      cyc_n(1);
    end
    in_wr[0] = 5'd0;
    for (int i = 0; i < 5; i++) begin
      cyc_n(1);
      n_vec++;
      if (ob_wr[0][2] !== 1'b0) begin
        n_err++; $display("FAIL bp_hold cycle %0d: wr2=%b, want 0", i, ob_wr[0][2]);
      end
    end
    in_nfull[0] = 5'd0;
    for (int i = 0; i < 3; i++) begin
      cyc_n(1);
      n_vec++;
      if (ob_wr[0][2] !== 1'b1 || ob_pk[0][32 +: 16] !== 16'h1001 + 16'(i)) begin
        n_err++; $display("FAIL bp_release %0d: wr2=%b lane2=%h, want 1 %h", i, ob_wr[0][2], ob_pk[0][32 +: 16], 16'h1001 + 16'(i));
      end
    end
    cyc_n(1);
    n_vec++;
    if (ob_wr[0][2] !== 1'b0) begin
      n_err++; $display("FAIL bp_after: wr2=%b, want 0", ob_wr[0][2]);
    end
  endtask

  task automatic test_overflow();
    int got;
    do_reset();
    in_nfull[0] = 5'b00100;
    for (int i = 0; i < 9; i++) begin
      in_wr[0] = 5'b00001;
      in_pk[0][15:0] = 16'h1100 + 16'(i);
      cyc_n(1);
      n_vec++;
      if (ob_full[0][0] !== (i >= 7) || ob_ovf[0][0] !== (i == 8)) begin
        n_err++; $display("FAIL ovf_write %0d: full=%b ovf=%b, want %b %b", i, ob_full[0][0], ob_ovf[0][0], (i >= 7), (i == 8));
      end
    end
    in_wr[0] = 5'd0;
    cyc_n(1);
    n_vec++;
    if (ob_ovf[0][0] !== 1'b0) begin
      n_err++; $display("FAIL ovf_pulse_end: ovf=%b, want 0", ob_ovf[0][0]);
    end
    in_nfull[0] = 5'd0;
    got = 0;
    for (int i = 0; i < 20; i++) begin
      cyc_n(1);
      if (ob_wr[0][2] === 1'b1) begin
        n_vec++;
        if (ob_pk[0][32 +: 16] !== 16'h1100 + 16'(got)) begin
          n_err++; $display("FAIL ovf_order %0d: lane2=%h, want %h", got, ob_pk[0][32 +: 16], 16'h1100 + 16'(got));
        end
        got++;
      end
    end
    n_vec++;
    if (got != 8) begin
      n_err++; $display("FAIL ovf_count: got %0d packets, want 8", got);
    end
  endtask

  task automatic test_contention();
    logic [15:0] exp_pk [3];
    exp_pk = '{16'h0011, 16'h0033, 16'h0044};
    do_reset();
    in_wr[0] = 5'b11010;
    in_pk[0][16 +: 16] = exp_pk[0];
    in_pk[0][48 +: 16] = exp_pk[1];
    in_pk[0][64 +: 16] = exp_pk[2];
    cyc_n(1);
    in_wr[0] = 5'd0;
    cyc_n(1);
    for (int i = 0; i < 3; i++) begin
      cyc_n(1);
      n_vec++;
      if (ob_wr[0] !== 5'b00001 || ob_pk[0][15:0] !== exp_pk[i]) begin
        n_err++; $display("FAIL rr_order %0d: wr=%b lane0=%h, want 00001 %h", i, ob_wr[0], ob_pk[0][15:0], exp_pk[i]);
      end
    end
  endtask

  task automatic test_fixed_priority();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      in_wr[1] = 5'b00110;
      in_pk[1][16 +: 16] = {8'h21, 4'h1, 4'(i)};
      in_pk[1][32 +: 16] = {8'h21, 4'h2, 4'(i)};
      cyc_n(1);
      if (i >= 2) begin
        n_vec++;
        if (ob_wr[1][0] !== 1'b1 || ob_pk[1][7:4] !== 4'h1) begin
          n_err++; $display("FAIL fixed_prio %0d: wr0=%b lane0=%h, want 1 from port 1", i, ob_wr[1][0], ob_pk[1][15:0]);
        end
      end
    end
    in_wr[1] = 5'd0;
    cyc_n(20);
  endtask

  task automatic test_dropped_route();
    do_reset();
    for (int i = 0; i < 10; i++) begin
      in_wr[1] = 5'b00001;
      in_pk[1][15:0] = 16'h1190 + 16'(i);
      cyc_n(1);
      n_vec++;
      if (ob_wr[1] !== 5'd0 || ob_full[1] !== 5'd0 || ob_ovf[1] !== 5'd0) begin
        n_err++; $display("FAIL drop_west %0d: wr=%b full=%b ovf=%b, want zeros", i, ob_wr[1], ob_full[1], ob_ovf[1]);
      end
    end
    in_pk[1][15:0] = 16'h21AB;
    cyc_n(1);
    in_wr[1] = 5'd0;
    cyc_n(4);
    n_vec++;
    if (ob_pk[1][15:0] !== 16'h21AB) begin
      n_err++; $display("FAIL drop_drain: lane0=%h, want 21ab", ob_pk[1][15:0]);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      for (int d = 0; d < ND; d++) begin
        for (int p = 0; p < 5; p++) begin
          in_wr[d][p]    = ($urandom_range(0, 99) < 45);
          in_nfull[d][p] = ($urandom_range(0, 99) < 15);
          in_novf[d][p]  = ($urandom_range(0, 99) < 5);
          in_pk[d][p*16 +: 16] = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)), 8'($urandom)};
        end
      end
      cyc_n(1);
    end
    rst = 1'b0;
    clear_inputs();
    cyc_n(40);
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_routing();
    test_backpressure();
    test_overflow();
    test_contention();
    test_fixed_priority();
    test_dropped_route();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
